// File: rtl/sub_word_sequencer.sv
// Streaming multi-word subtractor: chains the borrow across LSW-first word pairs
// and registers one difference word per accepted beat. Optional feature macro:
// SUB_ZERO_FLAG_EN adds the out_zero port and a sticky per-packet zero flag.

module n_subtractor #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] diff,
  output logic         bout
);

  logic [N:0] w_full;

  // The extra MSB of the widened difference is the borrow-out.
  assign w_full = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
  assign diff   = w_full[N-1:0];
  assign bout   = w_full[N];

endmodule

module sub_word_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_first,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_diff,
  output logic         out_bout,
`ifdef SUB_ZERO_FLAG_EN
  output logic         out_zero,
`endif
  output logic         out_last
);

  typedef enum logic {
    ST_IDLE,
    ST_CHAIN
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic         r_borrow;
  logic         r_out_valid;
  logic [N-1:0] r_out_diff;
  logic         r_out_bout;
  logic         r_out_last;

  logic         w_accept;
  logic         w_start;
  logic         w_bin;
  logic [N-1:0] w_diff;
  logic         w_bout;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  // Any beat that opens a packet, explicitly or from IDLE, ignores the stored borrow.
  assign w_start  = in_first || (r_state == ST_IDLE);
  assign w_bin    = w_start ? 1'b0 : r_borrow;

  n_subtractor #(.N(N)) u_sub (
    .a    (in_a),
    .b    (in_b),
    .bin  (w_bin),
    .diff (w_diff),
    .bout (w_bout)
  );

  always_comb begin
    // NOTE: default assigned first so every path drives w_state_next; no latch is inferred.
    w_state_next = r_state;
    if (w_accept) begin
      w_state_next = in_last ? ST_IDLE : ST_CHAIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: non-blocking assignment so all flops sample pre-edge values together.
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_diff  <= '0;
      r_out_bout  <= 1'b0;
      r_out_last  <= 1'b0;
      r_borrow    <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_diff  <= w_diff;
      r_out_bout  <= w_bout;
      r_out_last  <= in_last;
      r_borrow    <= w_bout;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_diff  = r_out_diff;
  assign out_bout  = r_out_bout;
  assign out_last  = r_out_last;

`ifdef SUB_ZERO_FLAG_EN
  logic r_zero_acc;
  logic r_out_zero;
  logic w_zero;

  assign w_zero = (w_diff == '0) && (w_start || r_zero_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_acc <= 1'b0;
      r_out_zero <= 1'b0;
    end else if (w_accept) begin
      r_zero_acc <= w_zero;
      r_out_zero <= w_zero;
    end
  end

  assign out_zero = r_out_zero;
`endif

endmodule

// File: tb/tb_sub_word_sequencer.sv
// Self-checking bench for sub_word_sequencer: directed cases from the test plan,
// then randomized packets scored against a full-width arithmetic reference model.

module tb_sub_word_sequencer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_first;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_diff;
  logic         out_bout;
  logic         out_last;
  logic         out_zero;

  always #5 clk = ~clk;

  sub_word_sequencer #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .out_bout  (out_bout),
`ifdef SUB_ZERO_FLAG_EN
    .out_zero  (out_zero),
`endif
    .out_last  (out_last)
  );

`ifndef SUB_ZERO_FLAG_EN
  assign out_zero = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] diff;
    logic         bout;
    logic         last;
    logic         zero;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model: running full-width minuend/subtrahend prefixes of the open packet.
  bit              m_open = 1'b0;
  longint unsigned m_a    = 0;
  longint unsigned m_b    = 0;
  int              m_idx  = 0;

  bit           force_en  = 1'b1;
  bit           force_val = 1'b1;
  bit           accepted  = 1'b0;
  bit           prev_stall = 1'b0;
  logic [N-1:0] snap_diff;
  logic         snap_bout;
  logic         snap_last;
  logic         snap_zero;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic first, input logic last);
    exp_t            e;
    longint unsigned mask;
    longint unsigned d;
    if (first || !m_open) begin
      m_a   = 0;
      m_b   = 0;
      m_idx = 0;
    end
    m_a   = m_a + (longint'(a) << (N * m_idx));
    m_b   = m_b + (longint'(b) << (N * m_idx));
    m_idx = m_idx + 1;
    mask  = (64'd1 << (N * m_idx)) - 64'd1;
    d     = (m_a - m_b) & mask;
    e.diff = N'(d >> (N * (m_idx - 1)));
    e.bout = (m_a < m_b);
    e.last = last;
    e.zero = (m_a == m_b);
    exp_q.push_back(e);
    m_open = !last;
  endtask

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (prev_stall) begin
      check("hold_diff", out_diff, snap_diff);
      check("hold_bout", out_bout, snap_bout);
      check("hold_last", out_last, snap_last);
`ifdef SUB_ZERO_FLAG_EN
      check("hold_zero", out_zero, snap_zero);
`endif
    end
    out_ready = force_en ? force_val : ($urandom_range(0, 3) != 0);
    #1;
    check("out_valid", out_valid, exp_q.size() != 0);
    check("in_ready", in_ready, !out_valid || out_ready);
    if (out_valid && out_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("diff", out_diff, e.diff);
      check("bout", out_bout, e.bout);
      check("last", out_last, e.last);
`ifdef SUB_ZERO_FLAG_EN
      check("zero", out_zero, e.zero);
`endif
    end
    accepted = in_valid && in_ready;
    if (accepted) model_accept(in_a, in_b, in_first, in_last);
    prev_stall = out_valid && !out_ready;
    snap_diff  = out_diff;
    snap_bout  = out_bout;
    snap_last  = out_last;
    snap_zero  = out_zero;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic send_beat(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic first, input logic last, output int tries);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_first = first;
    in_last  = last;
    tries    = 0;
    do begin
      cycle();
      tries++;
    end while (!accepted && tries < 20);
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    force_en  = 1'b1;
    force_val = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      idle_cycle();
      n++;
    end
    idle_cycle();
    check("drained", exp_q.size(), 0);
  endtask

  initial begin
    int t;
    int n_emit;
    int len;
    bit abandon;
    logic f;
    logic l;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_diff", out_diff, 0);
    check("rst_out_bout", out_bout, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 0x25 - 0x13 = 0x12
    send_beat(4'h5, 4'h3, 1'b1, 1'b0, t);
    send_beat(4'h2, 4'h1, 1'b0, 1'b1, t);
    // 0x20 - 0x01 = 0x1F, borrow chained
    send_beat(4'h0, 4'h1, 1'b1, 1'b0, t);
    send_beat(4'h2, 4'h0, 1'b0, 1'b1, t);
    // Underflow, then a single-word zero packet
    send_beat(4'h0, 4'h1, 1'b1, 1'b0, t);
    send_beat(4'h0, 4'h0, 1'b0, 1'b1, t);
    send_beat(4'hA, 4'hA, 1'b1, 1'b1, t);
    drain();

    // Backpressure mid-packet: stored borrow must survive a 3-cycle stall.
    send_beat(4'h0, 4'h1, 1'b1, 1'b0, t);
    force_val = 1'b0;
    in_valid  = 1'b1;
    in_a      = 4'h2;
    in_b      = 4'h0;
    in_first  = 1'b0;
    in_last   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_no_accept", accepted, 0);
    end
    force_val = 1'b1;
    send_beat(4'h2, 4'h0, 1'b0, 1'b1, t);
    check("bp_release_tries", t, 1);
    for (int i = 0; i < 4; i++) begin
      send_beat(4'(i + 3), 4'(2 * i), (i == 0), (i == 3), t);
      check("throughput_tries", t, 1);
    end
    drain();

    // Restart: an in_first beat abandons the open packet.
    send_beat(4'h0, 4'h1, 1'b1, 1'b0, t);
    send_beat(4'h7, 4'h2, 1'b1, 1'b1, t);
    drain();

    // Reset mid-packet drops everything; next beat starts with no borrow.
    send_beat(4'h0, 4'h1, 1'b1, 1'b0, t);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_diff", out_diff, 0);
    exp_q.delete();
    m_open     = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(4'h2, 4'h3, 1'b0, 1'b1, t);
    drain();

    // Randomized packets with random backpressure, gaps, abandons and missing in_first.
    force_en = 1'b0;
    for (int p = 0; p < 300; p++) begin
      len     = $urandom_range(1, 5);
      abandon = ($urandom_range(0, 9) == 0) && (len > 1);
      n_emit  = abandon ? len - 1 : len;
      for (int w = 0; w < n_emit; w++) begin
        f = (w == 0);
        if (w == 0 && $urandom_range(0, 7) == 0 && m_idx < 8) f = 1'b0;
        l = !abandon && (w == len - 1);
        repeat ($urandom_range(0, 1)) idle_cycle();
        send_beat(N'($urandom), N'($urandom), f, l, t);
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sub_word_sequencer.md
# sub_word_sequencer

Streaming multi-word subtractor front end that sits directly upstream of `n_subtractor` and drives its `a`, `b` and `bin` inputs. Operands wider than N bits arrive as a packet of N-bit word pairs, least-significant word first. The block chains the borrow between beats in a register and emits one registered difference word per accepted beat. The final beat of a packet carries the overall borrow-out.

## Interface
- `N`, default 4: word width in bits; must be ≥ 1; passed to the internal `n_subtractor`.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `in_valid`  input  1  an input word pair is presented.
- `in_ready`  output  1  the block can accept a word pair this cycle.
- `in_a`  input  N  minuend word.
- `in_b`  input  N  subtrahend word.
- `in_first`  input  1  this beat is the least-significant word of a new packet.
- `in_last`  input  1  this beat is the most-significant word of the packet.
- `out_valid`  output  1  `out_diff` and its side-band outputs are valid.
- `out_ready`  input  1  the downstream consumer accepts the output word.
- `out_diff`  output  N  difference word, `in_a - in_b - bin` mod 2^N.
- `out_bout`  output  1  borrow-out of this beat; meaningful as the packet borrow only when `out_last` = 1.
- `out_last`  output  1  copy of `in_last` for this beat.
- `out_zero`  output  1  present only with `SUB_ZERO_FLAG_EN`; see Configuration.

## Operation
- Accept condition: `in_valid && in_ready`. Output transfer condition: `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is a single-entry output register with pass-through backpressure and no skid buffer.
- State machine:
  - IDLE: waiting for a packet start.
  - CHAIN: inside a packet; the borrow register holds the borrow from the previous beat.
- Borrow-in selection for an accepted beat:
  - `bin = 0` if `in_first` = 1 or state = IDLE.
  - Otherwise `bin` = the borrow register.
- On an accepted beat:
  - `out_diff` ← `n_subtractor.diff`; `out_bout` ← `n_subtractor.bout`; `out_last` ← `in_last`.
  - The borrow register ← `bout`.
  - Next state = IDLE if `in_last` = 1, else CHAIN.
- An `in_first` beat while in CHAIN abandons the open packet and restarts the chain with `bin = 0`. No error is flagged.
- A beat without `in_first` while in IDLE is treated as a packet start (`bin = 0`).
- A beat with `in_first` = `in_last` = 1 is a single-word packet, equivalent to a direct `n_subtractor` call with `bin = 0`.
- Arithmetic is unsigned modulo 2^N per word. The packet result is unsigned modulo 2^(N·words). Final `out_bout` = 1 means the full-width minuend < subtrahend.

## Timing
- Reset values: `out_valid` = 0, `out_diff` = 0, `out_bout` = 0, `out_last` = 0, `out_zero` = 0, borrow register = 0, state = IDLE. After reset, `in_ready` = 1.
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 beat per cycle while `out_ready` = 1.
- With `out_valid` = 1 and `out_ready` = 0:
  - `in_ready` = 0.
  - All outputs hold stable.
  - The borrow register and state do not change.
- Simultaneous output transfer and new input accept in the same cycle: the register reloads with the new beat and `out_valid` stays 1.
- Output transfer with no accept: `out_valid` → 0 on the next edge.
- Reset asserted mid-packet: outputs and state return to reset values immediately. The partial packet is dropped, and the first beat after release starts with `bin = 0`.

## Configuration
- `SUB_ZERO_FLAG_EN` defined:
  - The `out_zero` port and a sticky zero accumulator exist.
  - On each accepted beat, `out_zero` = (`diff` == 0) AND (accumulated zero, or 1 if this is a packet start).
  - On the `out_last` beat, `out_zero` = 1 iff the whole packet difference is zero.
- `SUB_ZERO_FLAG_EN` undefined: neither the `out_zero` port nor the accumulator exists. All other behaviour is identical.

## Test plan
- N=4, reset, then 2-beat packet (5,3,first) → (2,1,last) → `out_diff` 2 then 1, final `out_bout` = 0 (0x25 − 0x13 = 0x12).
- Borrow chain: (0,1,first) → (2,0,last) → diff F with bout 1, then diff 1 with bout 0 (0x20 − 0x01 = 0x1F).
- Underflow: (0,1,first) → (0,0,last) → diff F then F, final `out_bout` = 1. With `SUB_ZERO_FLAG_EN`, `out_zero` = 0. Also run (A,A,first,last) → diff 0, `out_zero` = 1.
- Backpressure: hold `out_ready` = 0 for 3 cycles mid-packet.
  - Required: `in_ready` = 0 and outputs stable during the hold.
  - On release, the next beat still uses the stored borrow.
  - Throughput returns to 1 beat/cycle.
- Restart: (0,1,first) then (7,2,first,last) → second diff 5, `bin` = 0, `out_bout` = 0. Also deassert `rst_n` mid-packet → `out_valid` = 0 at once, and the next beat (2,3) → diff F, bout 1 with no stale borrow.
